// File: rtl/axis_mem_tx_pkg.sv
// axis_mem_tx_pkg: control-word field positions and the sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_mem_tx_pkg;

  // Control word layout. Bits not listed here are reserved and ignored.
  localparam int TKEEP_LSB = 0;
  localparam int TKEEP_W   = 8;
  localparam int TLAST_BIT = 8;
  localparam int EOL_BIT   = 9;
  localparam int GAP_LSB   = 16;
  localparam int GAP_W     = 8;
  localparam int VALID_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_GAP,
    ST_SEND,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [GAP_W-1:0]   gap;
    logic               eol;
    logic               tlast;
    logic [TKEEP_W-1:0] tkeep;
  } ctrl_t;

endpackage

// File: rtl/axis_mem_tx_ctrl_decode.sv
// axis_mem_tx_ctrl_decode: splits a stimulus control word into its fields.
// Latency: purely combinational.
// Backpressure: none; follows the memory output directly.
module axis_mem_tx_ctrl_decode
  import axis_mem_tx_pkg::*;
(
  input  logic [31:0] ctrl_word,
  output ctrl_t       fields
);

  assign fields.tkeep = ctrl_word[TKEEP_LSB +: TKEEP_W];
  assign fields.tlast = ctrl_word[TLAST_BIT];
  assign fields.eol   = ctrl_word[EOL_BIT];
  assign fields.gap   = ctrl_word[GAP_LSB +: GAP_W];
  assign fields.valid = ctrl_word[VALID_BIT];

  // Reserved bits carry no meaning for the sequencer.
  logic unused_rsvd;
  assign unused_rsvd = ^{ctrl_word[15:10], ctrl_word[30:24]};

endmodule

// File: rtl/axis_mem_tx_master.sv
// axis_mem_tx_master: walks stimulus memory from base_addr, one AXI-Stream beat per valid entry.
// Latency: FETCH one cycle after start, first tvalid two cycles after start plus gap; 1 beat/cycle at gap 0.
// Backpressure: beat held stable while tready low; next entry prefetched only on handshake. Loop option: AXIS_MEM_TX_LOOP_EN.
module axis_mem_tx_master
  import axis_mem_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    tx_mac_aclk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic                    stop,
  output logic [31:0]             mem_wr_address,
  input  logic [31:0]             mem_axis_wctrl,
  input  logic [DATA_WIDTH-1:0]   mem_axis_wdata,
  output logic [DATA_WIDTH-1:0]   tx_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] tx_axis_tkeep,
  output logic                    tx_axis_tlast,
  output logic                    tx_axis_tvalid,
  input  logic                    tx_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic                    err_invalid,
  output logic [15:0]             beat_cnt
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  cur_eol;
  ctrl_t                 dec;

  logic hs;
  logic fetch;
  logic tvalid_next;
  logic load_entry;
  logic load_gap;
  logic set_err;
  logic start_acc;
  logic reload_base;
  logic loop_cont;

  axis_mem_tx_ctrl_decode u_decode (
    .ctrl_word (mem_axis_wctrl),
    .fields    (dec)
  );

`ifdef AXIS_MEM_TX_LOOP_EN
  assign loop_cont = ~stop;
`else
  logic unused_stop;
  assign unused_stop = stop;
  assign loop_cont   = 1'b0;
`endif

  assign hs             = tx_axis_tvalid & tx_axis_tready;
  assign mem_wr_address = 32'(addr);
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE);

  // State register.
  always_ff @(posedge tx_mac_aclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and datapath strobes; FETCH and the SEND prefetch share one entry decode.
  always_comb begin
    state_next  = state;
    tvalid_next = tx_axis_tvalid;
    fetch       = 1'b0;
    load_entry  = 1'b0;
    load_gap    = 1'b0;
    set_err     = 1'b0;
    start_acc   = 1'b0;
    reload_base = 1'b0;
    case (state)
      ST_IDLE: begin
        tvalid_next = 1'b0;
        if (start) begin
          start_acc  = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: fetch = 1'b1;
      ST_GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_next  = ST_SEND;
          tvalid_next = 1'b1;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (cur_eol) begin
            tvalid_next = 1'b0;
            if (loop_cont) begin
              reload_base = 1'b1;
              state_next  = ST_FETCH;
            end else begin
              state_next = ST_DONE;
            end
          end else begin
            fetch = 1'b1;
          end
        end
      end
      ST_DONE: begin
        tvalid_next = 1'b0;
        state_next  = ST_IDLE;
      end
      default: begin
        tvalid_next = 1'b0;
        state_next  = ST_IDLE;
      end
    endcase
    if (fetch) begin
      if (!dec.valid) begin
        set_err     = 1'b1;
        tvalid_next = 1'b0;
        state_next  = ST_DONE;
      end else if (dec.gap != '0) begin
        load_entry  = 1'b1;
        load_gap    = 1'b1;
        tvalid_next = 1'b0;
        state_next  = ST_GAP;
      end else begin
        load_entry  = 1'b1;
        tvalid_next = 1'b1;
        state_next  = ST_SEND;
      end
    end
  end

  // Address walk: latch base on start, reload it on a loop, step on every fetch (wraps naturally).
  always_ff @(posedge tx_mac_aclk) begin
    if (reset) begin
      addr   <= '0;
      base_q <= '0;
    end else if (start_acc) begin
      addr   <= base_addr;
      base_q <= base_addr;
    end else if (reload_base) begin
      addr <= base_q;
    end else if (fetch) begin
      addr <= addr + 1'b1;
    end
  end

  // Beat registers; they only change on a fetch, so a stalled beat stays stable.
  always_ff @(posedge tx_mac_aclk) begin
    if (reset) begin
      tx_axis_tdata  <= '0;
      tx_axis_tkeep  <= '0;
      tx_axis_tlast  <= 1'b0;
      tx_axis_tvalid <= 1'b0;
      cur_eol        <= 1'b0;
    end else begin
      tx_axis_tvalid <= tvalid_next;
      if (load_entry) begin
        tx_axis_tdata <= mem_axis_wdata;
        tx_axis_tkeep <= KEEP_W'(dec.tkeep);
        tx_axis_tlast <= dec.tlast;
        cur_eol       <= dec.eol;
      end
    end
  end

  // Idle-gap countdown ahead of a beat.
  always_ff @(posedge tx_mac_aclk) begin
    if (reset)                 gap_cnt <= '0;
    else if (load_gap)         gap_cnt <= dec.gap;
    else if (state == ST_GAP)  gap_cnt <= gap_cnt - 1'b1;
  end

  // Run status: invalid-entry flag and saturating handshake count, both cleared by start.
  always_ff @(posedge tx_mac_aclk) begin
    if (reset) begin
      err_invalid <= 1'b0;
      beat_cnt    <= '0;
    end else if (start_acc) begin
      err_invalid <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      if (set_err) err_invalid <= 1'b1;
      if (hs && beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_mem_tx_master.sv
// tb_axis_mem_tx_master: randomized and directed runs against a list-walking reference model.
// Latency: n/a.
// Backpressure: tready driven constant, randomized, or with a fixed mid-run stall.
module tb_axis_mem_tx_master;

  logic        clk = 1'b0;
  logic        reset, start, stop, tready;
  logic [15:0] base_addr;
  logic [31:0] mem_wr_address, mem_axis_wctrl;
  logic [63:0] mem_axis_wdata, tx_axis_tdata;
  logic [7:0]  tx_axis_tkeep;
  logic        tx_axis_tlast, tx_axis_tvalid, busy, done, err_invalid;
  logic [15:0] beat_cnt;

  always #5 clk = ~clk;

  logic [31:0] mem_ctrl [65536];
  logic [63:0] mem_data [65536];
  assign mem_axis_wctrl = mem_ctrl[mem_wr_address[15:0]];
  assign mem_axis_wdata = mem_data[mem_wr_address[15:0]];

  axis_mem_tx_master #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) dut (
    .tx_mac_aclk    (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .stop           (stop),
    .mem_wr_address (mem_wr_address),
    .mem_axis_wctrl (mem_axis_wctrl),
    .mem_axis_wdata (mem_axis_wdata),
    .tx_axis_tdata  (tx_axis_tdata),
    .tx_axis_tkeep  (tx_axis_tkeep),
    .tx_axis_tlast  (tx_axis_tlast),
    .tx_axis_tvalid (tx_axis_tvalid),
    .tx_axis_tready (tready),
    .busy           (busy),
    .done           (done),
    .err_invalid    (err_invalid),
    .beat_cnt       (beat_cnt)
  );

`ifdef AXIS_MEM_TX_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          idle;
  } beat_t;

  beat_t exp_q[$];
  bit    exp_err;
  int    exp_beats;
  int    checks = 0;
  int    failures = 0;

  bit    mon_en = 1'b0;
  int    rdy_mode = 0;   // 0 always ready, 1 random, 2 five-cycle stall after first beat, 3 never
  int    stop_mode = 0;  // 0 low, 1 random, 2 high once hs_cnt reaches stop_thr, 3 high
  int    stop_thr = 0;
  int    hs_cnt = 0;

  logic        log_vld  [0:2047];
  logic        log_done [0:2047];
  logic [31:0] log_addr [0:2047];
  int          nlog;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference walk: each pass starts at base; stop at an invalid entry or after EOL.
  task automatic build_model(input logic [15:0] base, input int npass);
    logic [15:0] a;
    logic [31:0] c;
    beat_t       b;
    bit          first;
    exp_q.delete();
    exp_err   = 1'b0;
    exp_beats = 0;
    for (int p = 0; p < npass; p++) begin
      a     = base;
      first = 1'b1;
      for (int k = 0; k < 1024; k++) begin
        c = mem_ctrl[a];
        if (!c[31]) begin
          exp_err = 1'b1;
          break;
        end
        b.data = mem_data[a];
        b.keep = c[7:0];
        b.last = c[8];
        b.idle = int'(c[23:16]) + (first ? 1 : 0);
        exp_q.push_back(b);
        exp_beats++;
        first = 1'b0;
        a     = a + 16'd1;
        if (c[9]) break;
      end
      if (exp_err) break;
    end
  endtask

  task automatic gen_entry(input logic [15:0] a, input bit valid, input bit eol, input int gap);
    logic [31:0] c;
    c        = $urandom;
    c[31]    = valid;
    c[9]     = eol;
    c[23:16] = 8'(gap);
    mem_ctrl[a] = c;
    mem_data[a] = {$urandom, $urandom};
  endtask

  task automatic gen_list(input logic [15:0] base, input int n, input bit allow_inv, input int maxgap);
    for (int k = 0; k < n; k++)
      gen_entry(base + 16'(k), !(allow_inv && $urandom_range(0, 7) == 0), k == n - 1,
                $urandom_range(0, maxgap));
  endtask

  task automatic run_case(input logic [15:0] base, input int npass, input int limit);
    build_model(base, npass);
    @(posedge clk); #1;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 16'($urandom);
    nlog      = 0;
    forever begin
      @(negedge clk);
      nlog++;
      log_vld[nlog]  = tx_axis_tvalid;
      log_done[nlog] = done;
      log_addr[nlog] = mem_wr_address;
      if (done || nlog >= limit) break;
    end
    check("done_seen", done, 1);
    check("end_err_invalid", err_invalid, exp_err);
    check("end_beat_cnt", beat_cnt, 16'(exp_beats));
    check("beats_left", exp_q.size(), 0);
  endtask

  // Downstream ready and stop drivers.
  initial begin
    int stall_n;
    tready  = 1'b1;
    stop    = 1'b0;
    stall_n = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tready = 1'b1;
        1: tready = ($urandom_range(0, 3) != 0);
        2: if (busy && hs_cnt >= 1 && stall_n < 5) begin
             tready = 1'b0;
             stall_n++;
           end else tready = 1'b1;
        default: tready = 1'b0;
      endcase
      if (rdy_mode != 2) stall_n = 0;
      case (stop_mode)
        0: stop = 1'b0;
        1: stop = ($urandom_range(0, 1) != 0);
        2: stop = (hs_cnt >= stop_thr);
        default: stop = 1'b1;
      endcase
    end
  end

  // Compare process: every handshake against the model, every stalled cycle for stability.
  int          idle_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;
  always @(negedge clk) begin
    beat_t e;
    if (!mon_en) begin
      prev_stall = 1'b0;
      idle_cnt   = 0;
    end else begin
      if (start && !busy) begin
        idle_cnt = 0;
        hs_cnt   = 0;
      end
      if (prev_stall) begin
        check("stall_tvalid", tx_axis_tvalid, 1);
        check("stall_tdata", tx_axis_tdata, prev_data);
        check("stall_tkeep", tx_axis_tkeep, prev_keep);
        check("stall_tlast", tx_axis_tlast, prev_last);
      end
      if (tx_axis_tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_tdata", tx_axis_tdata, e.data);
          check("beat_tkeep", tx_axis_tkeep, e.keep);
          check("beat_tlast", tx_axis_tlast, e.last);
          check("beat_idle_cycles", 64'(idle_cnt), 64'(e.idle));
        end
        idle_cnt = 0;
        hs_cnt++;
      end else if (busy && !tx_axis_tvalid) begin
        idle_cnt++;
      end
      if (busy) check("addr_upper_zero", mem_wr_address[31:16], 0);
      prev_stall = tx_axis_tvalid && !tready;
      prev_data  = tx_axis_tdata;
      prev_keep  = tx_axis_tkeep;
      prev_last  = tx_axis_tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:1] pat;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    stop_mode = LOOP ? 3 : 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", tx_axis_tvalid, 0);
    check("rst_tlast", tx_axis_tlast, 0);
    check("rst_tdata", tx_axis_tdata, 0);
    check("rst_tkeep", tx_axis_tkeep, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err_invalid", err_invalid, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_mem_addr", mem_wr_address, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Three back-to-back beats at 0x0010.
    for (int k = 0; k < 3; k++) gen_entry(16'h0010 + 16'(k), 1'b1, k == 2, 0);
    rdy_mode = 0;
    run_case(16'h0010, 1, 50);
    pat = 5'b01110;
    for (int i = 1; i <= 5; i++) check("t1_tvalid_cycle", log_vld[i], pat[i]);
    check("t1_done_cycle", log_done[5], 1);
    check("t1_run_length", 64'(nlog), 5);
    check("t1_beat_cnt", beat_cnt, 3);

    // Single entry with gap 4.
    gen_entry(16'h0040, 1'b1, 1'b1, 4);
    run_case(16'h0040, 1, 50);
    for (int i = 1; i <= 5; i++) check("t2_gap_low", log_vld[i], 0);
    check("t2_beat_after_gap", log_vld[6], 1);

    // Five-cycle stall after the first beat.
    gen_list(16'h0100, 4, 1'b0, 0);
    rdy_mode = 2;
    run_case(16'h0100, 1, 50);
    check("t3_beat_cnt", beat_cnt, 4);
    rdy_mode = 0;

    // Second entry invalid.
    gen_entry(16'h0200, 1'b1, 1'b0, 0);
    gen_entry(16'h0201, 1'b0, 1'b0, 0);
    run_case(16'h0200, 1, 50);
    check("t4_err_invalid", err_invalid, 1);
    check("t4_beat_cnt", beat_cnt, 1);

    // Address wrap.
    gen_entry(16'hFFFF, 1'b1, 1'b0, 0);
    gen_entry(16'h0000, 1'b1, 1'b1, 0);
    run_case(16'hFFFF, 1, 50);
    check("t5_addr_first", log_addr[1], 32'h0000_FFFF);
    check("t5_addr_second", log_addr[2], 32'h0000_0000);
    check("t5_err_cleared", err_invalid, 0);

`ifdef AXIS_MEM_TX_LOOP_EN
    // Two-entry loop, stop raised during the third pass.
    gen_list(16'h0300, 2, 1'b0, 1);
    stop_thr  = 4;
    stop_mode = 2;
    run_case(16'h0300, 3, 200);
    check("loop_beat_cnt", beat_cnt, 6);
    stop_mode = 3;
`endif

    // Reset with a beat pending.
    gen_entry(16'h0400, 1'b1, 1'b1, 0);
    rdy_mode = 3;
    @(posedge clk); #1;
    base_addr = 16'h0400;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 20 && !tx_axis_tvalid; t++) @(negedge clk);
    check("rst_mid_pending", tx_axis_tvalid, 1);
    @(posedge clk); #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_tvalid", tx_axis_tvalid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_beat_cnt", beat_cnt, 0);
    reset    = 1'b0;
    rdy_mode = 0;
    exp_q.delete();
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Randomized lists, bases, gaps and backpressure.
    rdy_mode  = 1;
    stop_mode = LOOP ? 3 : 1;
    for (int r = 0; r < 16; r++) begin
      logic [15:0] b;
      b = 16'($urandom);
      gen_list(b, $urandom_range(1, 6), 1'b1, 3);
      run_case(b, 1, 400);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
